seq_controller_ws: RTL

Parametrised successor to the VeriRISC sequence controller: the same eight-phase instruction FSM, extended with three additions. Memory phases can be stretched by a `mem_ready` handshake, with a wait-state timeout. `HLT` parks the FSM in a resumable halted state. A single-step mode pauses after every instruction. The block sits between the instruction register/decoder and the datapath (PC, AC, memory), driving the same control strobes as its predecessor plus status outputs for the debug port.

---
 rtl/seq_controller_ws.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seq_controller_ws.sv
// Opcode set shared by the instruction register, decoder and sequence controller.
// Encoding matches the original VeriRISC assignment.
// Pure type definitions, no logic.
package typedefs;
   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_t;
endpackage

// Eight-phase instruction sequencer with memory wait states, halt/resume and single-step.
// Latency: 8 cycles per zero-wait instruction, 5 cycles from fetch to HALTED for HLT.
// Backpressure: mem_ready low holds a memory phase with strobes asserted; MAX_WAIT held cycles force HALTED.
module seq_controller_ws
   import typedefs::*;
#(
   parameter int unsigned MAX_WAIT = 8,
   parameter int unsigned WAIT_W   = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  opcode_t          opcode,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             step_mode,
   input  logic             resume,
   output logic             mem_rd,
   output logic             load_ir,
   output logic             halt,
   output logic             inc_pc,
   output logic             load_ac,
   output logic             load_pc,
   output logic             mem_wr,
   output logic             bus_err,
   output logic             paused,
   output logic [3:0]       phase,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8,
      PAUSED     = 4'd9
   } state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              aluop;
   logic              mem_phase;
   logic              timeout;

   assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

   // Phases that perform a memory access and therefore honour mem_ready
   assign mem_phase = (state == INST_FETCH) ||
                      ((state == OP_FETCH) && aluop) ||
                      ((state == STORE) && (opcode == OP_STO));

   // Timeout fires on the cycle the counter has already absorbed MAX_WAIT held cycles
   assign timeout = (MAX_WAIT != 0) && (wait_cnt == WAIT_W'(MAX_WAIT));

   assign phase  = 4'(state);
   assign paused = (state == PAUSED);

   // State, wait counter, sticky bus error and instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= INST_ADDR;
         wait_cnt    <= '0;
         bus_err     <= 1'b0;
         instr_count <= '0;
      end else if (mem_phase && !mem_ready) begin
         if (timeout) begin
            state    <= HALTED;
            bus_err  <= 1'b1;
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end else begin
         wait_cnt <= '0;
         case (state)
            INST_ADDR:  state <= INST_FETCH;
            INST_FETCH: state <= INST_LOAD;
            INST_LOAD:  state <= IDLE;
            IDLE:       state <= OP_ADDR;
            OP_ADDR: begin
               if (opcode == OP_HLT) begin
                  state       <= HALTED;
                  instr_count <= instr_count + CNT_W'(1);
               end else begin
                  state <= OP_FETCH;
               end
            end
            OP_FETCH:   state <= ALU_OP;
            ALU_OP:     state <= STORE;
            STORE: begin
               instr_count <= instr_count + CNT_W'(1);
               state       <= step_mode ? PAUSED : INST_ADDR;
            end
            HALTED: begin
               if (resume) begin
                  state   <= INST_ADDR;
                  bus_err <= 1'b0;
               end
            end
            PAUSED: begin
               if (resume) state <= INST_ADDR;
            end
            default:    state <= INST_ADDR;
         endcase
      end
   end

   // Datapath strobes decoded from the current phase, opcode and zero flag
   always_comb begin
      mem_rd  = 1'b0;
      load_ir = 1'b0;
      halt    = 1'b0;
      inc_pc  = 1'b0;
      load_ac = 1'b0;
      load_pc = 1'b0;
      mem_wr  = 1'b0;
      case (state)
         INST_FETCH: mem_rd = 1'b1;
         INST_LOAD, IDLE: begin
            mem_rd  = 1'b1;
            load_ir = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (opcode == OP_HLT);
         end
         OP_FETCH:   mem_rd = aluop;
         ALU_OP: begin
            mem_rd  = aluop;
            load_ac = aluop;
            inc_pc  = (opcode == OP_SKZ) && zero;
            load_pc = (opcode == OP_JMP);
         end
         STORE: begin
            mem_wr  = (opcode == OP_STO);
            inc_pc  = (opcode == OP_JMP);
            load_pc = (opcode == OP_JMP);
         end
         HALTED:     halt = 1'b1;
         default:    ;
      endcase
   end

endmodule
